axis_frame_length_fifo: RTL and testbench

AXIS_FRAME_LENGTH_FIFO -- requirements
Module: axis_frame_length_fifo

---
 rtl/axis_frame_length_fifo_pkg.sv | 18 +
 rtl/axis_frame_length_fifo_if.sv | 30 +++
 rtl/axis_frame_length_fifo_len_sync_fifo.sv | 54 +++++
 rtl/axis_frame_length_fifo.sv | 94 +++++++++
 tb/tb_axis_frame_length_fifo.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_frame_length_fifo_pkg.sv
// eth_len_pkg: shared constants and status layout for the frame-length FIFO
package eth_len_pkg;

    localparam int TUSER_BAD      = 0;
    localparam int TUSER_RUNT     = 1;
    localparam int TUSER_OVERSIZE = 2;
    localparam int TUSER_WIDTH    = 3;

    localparam int ETH_MIN_PACKET_LENGTH = 64;
    localparam int ETH_MAX_PACKET_LENGTH = 1522;

    typedef struct packed {
        logic oversize;
        logic runt;
        logic bad;
    } len_status_t;

endpackage

// File: rtl/axis_frame_length_fifo_if.sv
// axis_frame_length_fifo_if: monitored stream tap plus length-entry output stream
interface axis_frame_length_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 11
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_axis_tkeep;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic                  s_axis_tuser;
    logic [LEN_WIDTH-1:0]  m_len_tdata;
    logic [2:0]            m_len_tuser;
    logic                  m_len_tvalid;
    logic                  m_len_tready;

    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tready,
               s_axis_tlast, s_axis_tuser, m_len_tready,
        output m_len_tdata, m_len_tuser, m_len_tvalid
    );

    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tready,
               s_axis_tlast, s_axis_tuser, m_len_tready,
        input  m_len_tdata, m_len_tuser, m_len_tvalid
    );

endinterface

// File: rtl/axis_frame_length_fifo_len_sync_fifo.sv
// len_sync_fifo: single-clock FIFO with extra-bit pointers and push-while-full-with-pop
module len_sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   ready,
    output logic                   valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid     = rst && !empty;
    assign pop       = valid && ready;
    assign wr        = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign rd_data   = valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign occupancy = wr_ptr - rd_ptr;

    // storage write; a full FIFO reuses the slot being popped this cycle
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // pointer update, wrapping naturally modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/axis_frame_length_fifo.sv
// axis_frame_length_fifo: measures tapped AXIS frame lengths and queues them with status flags
module axis_frame_length_fifo
    import eth_len_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 11,
    parameter int DEPTH      = 64,
    parameter int MIN_LEN    = ETH_MIN_PACKET_LENGTH,
    parameter int MAX_LEN    = ETH_MAX_PACKET_LENGTH,
    parameter int DROP_BAD   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_frame_length_fifo_if.master   bus,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       status_overflow,
    output logic [15:0]                overflow_count
);
    localparam logic [LEN_WIDTH-1:0] LEN_SAT = '1;

    logic [LEN_WIDTH-1:0]         count;
    logic [LEN_WIDTH:0]           bytes;
    logic [LEN_WIDTH:0]           sum;
    logic [LEN_WIDTH-1:0]         total;
    logic                         beat;
    logic                         last;
    logic                         push;
    logic                         drop;
    len_status_t                  st;
    logic [LEN_WIDTH+2:0]         rd_data;
    logic                         unused_tap;

    assign unused_tap = ^{bus.s_axis_tdata, bus.s_axis_tkeep};

    // bytes carried by the current beat, saturating sum with the running count
    always_comb begin
        bytes = '0;
        if (KEEP_WIDTH == 1)
            bytes = (LEN_WIDTH+1)'(1);
        else
            for (int i = 0; i < KEEP_WIDTH; i++)
                bytes = bytes + (LEN_WIDTH+1)'(bus.s_axis_tkeep[i]);
        sum   = {1'b0, count} + bytes;
        total = sum[LEN_WIDTH] ? LEN_SAT : sum[LEN_WIDTH-1:0];
        st.oversize = 32'(total) > MAX_LEN;
        st.runt     = 32'(total) < MIN_LEN;
        st.bad      = bus.s_axis_tuser;
    end

    assign beat = bus.s_axis_tvalid && bus.s_axis_tready;
    assign last = beat && bus.s_axis_tlast;
    assign push = last && !((DROP_BAD != 0) && bus.s_axis_tuser);

    // running byte count of the frame in progress, cleared on its last beat
    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (last)
            count <= '0;
        else if (beat)
            count <= total;
    end

    len_sync_fifo #(
        .WIDTH (LEN_WIDTH + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wr_data   ({st, total}),
        .ready     (bus.m_len_tready),
        .valid     (bus.m_len_tvalid),
        .rd_data   (rd_data),
        .occupancy (occupancy),
        .drop      (drop)
    );

    assign {bus.m_len_tuser, bus.m_len_tdata} = rd_data;

    // lost-entry pulse and saturating lost-entry counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            status_overflow <= 1'b0;
            overflow_count  <= '0;
        end else begin
            status_overflow <= drop;
            if (drop && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_frame_length_fifo.sv
// tb_axis_frame_length_fifo: directed frames with queued expected entries and a popping monitor
module tb_axis_frame_length_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  occ8;
    logic [6:0]  occ32;
    logic        ovf8, ovf32;
    logic [15:0] cnt8, cnt32;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] q8[$];
    logic [13:0] q32[$];

    always #5 clk = ~clk;

    axis_frame_length_fifo_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1), .LEN_WIDTH(11)) bus8();
    axis_frame_length_fifo_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .LEN_WIDTH(11)) bus32();

    axis_frame_length_fifo #(
        .DATA_WIDTH(8), .KEEP_WIDTH(1), .LEN_WIDTH(11), .DEPTH(4),
        .MIN_LEN(64), .MAX_LEN(1522), .DROP_BAD(1)
    ) u8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .occupancy(occ8), .status_overflow(ovf8), .overflow_count(cnt8)
    );

    axis_frame_length_fifo #(
        .DATA_WIDTH(32), .KEEP_WIDTH(4), .LEN_WIDTH(11), .DEPTH(64),
        .MIN_LEN(64), .MAX_LEN(1522), .DROP_BAD(0)
    ) u32 (
        .clk(clk), .rst(rst), .bus(bus32),
        .occupancy(occ32), .status_overflow(ovf32), .overflow_count(cnt32)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // monitor: every handshake pops and compares the oldest expected entry
    always @(negedge clk) begin
        if (rst && bus8.m_len_tvalid && bus8.m_len_tready) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u8_unexpected_entry got 0x%0h expected none", {bus8.m_len_tuser, bus8.m_len_tdata});
            end else
                check("u8_entry", {18'd0, bus8.m_len_tuser, bus8.m_len_tdata}, {18'd0, q8.pop_front()});
        end
        if (rst && bus32.m_len_tvalid && bus32.m_len_tready) begin
            if (q32.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u32_unexpected_entry got 0x%0h expected none", {bus32.m_len_tuser, bus32.m_len_tdata});
            end else
                check("u32_entry", {18'd0, bus32.m_len_tuser, bus32.m_len_tdata}, {18'd0, q32.pop_front()});
        end
    end

    task automatic send8(input int n, input bit user, input bit last_en, input bit pop_last, input int stall);
        bit last;
        for (int i = 0; i < n; i++) begin
            if (i == stall) begin
                @(posedge clk); #1;
                bus8.s_axis_tvalid = 1'b1;
                bus8.s_axis_tready = 1'b0;
                bus8.s_axis_tlast  = 1'b1;
            end
            @(posedge clk); #1;
            last = last_en && (i == n - 1);
            bus8.s_axis_tvalid = 1'b1;
            bus8.s_axis_tready = 1'b1;
            bus8.s_axis_tdata  = 8'(i);
            bus8.s_axis_tlast  = last;
            bus8.s_axis_tuser  = user && last;
            if (pop_last && last)
                bus8.m_len_tready = 1'b1;
        end
        @(posedge clk); #1;
        bus8.s_axis_tvalid = 1'b0;
        bus8.s_axis_tlast  = 1'b0;
        bus8.s_axis_tuser  = 1'b0;
    endtask

    task automatic send32(input int n, input logic [3:0] last_keep, input bit user);
        bit last;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            last = (i == n - 1);
            bus32.s_axis_tvalid = 1'b1;
            bus32.s_axis_tready = 1'b1;
            bus32.s_axis_tdata  = 32'(i);
            bus32.s_axis_tkeep  = last ? last_keep : 4'hF;
            bus32.s_axis_tlast  = last;
            bus32.s_axis_tuser  = user && last;
        end
        @(posedge clk); #1;
        bus32.s_axis_tvalid = 1'b0;
        bus32.s_axis_tlast  = 1'b0;
        bus32.s_axis_tuser  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.s_axis_tdata  = '0; bus8.s_axis_tkeep  = 1'b1; bus8.s_axis_tvalid  = 1'b0;
        bus8.s_axis_tready = 1'b1; bus8.s_axis_tlast = 1'b0; bus8.s_axis_tuser  = 1'b0;
        bus8.m_len_tready  = 1'b1;
        bus32.s_axis_tdata = '0; bus32.s_axis_tkeep = 4'hF; bus32.s_axis_tvalid = 1'b0;
        bus32.s_axis_tready = 1'b1; bus32.s_axis_tlast = 1'b0; bus32.s_axis_tuser = 1'b0;
        bus32.m_len_tready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_occupancy", 32'(occ8), 0);
        check("reset_tvalid", 32'(bus8.m_len_tvalid), 0);
        check("reset_tdata", 32'(bus8.m_len_tdata), 0);
        check("reset_tuser", 32'(bus8.m_len_tuser), 0);
        check("reset_ovf_pulse", 32'(ovf8), 0);
        check("reset_ovf_count", 32'(cnt8), 0);
        rst = 1'b1;

        q8.push_back({3'b000, 11'd100});
        send8(100, 1'b0, 1'b1, 1'b0, 50);
        check("u8_visible_1cycle", 32'(bus8.m_len_tvalid), 1);

        q32.push_back({3'b010, 11'd62});
        send32(16, 4'h3, 1'b0);
        check("u32_visible_1cycle", 32'(bus32.m_len_tvalid), 1);
        q32.push_back({3'b001, 11'd80});
        send32(20, 4'hF, 1'b1);
        q32.push_back({3'b100, 11'd1600});
        send32(400, 4'hF, 1'b0);

        q8.push_back({3'b100, 11'd2000});
        send8(2000, 1'b0, 1'b1, 1'b0, -1);
        q8.push_back({3'b100, 11'd2047});
        send8(2100, 1'b0, 1'b1, 1'b0, -1);
        q8.push_back({3'b000, 11'd1522});
        send8(1522, 1'b0, 1'b1, 1'b0, -1);
        q8.push_back({3'b100, 11'd1523});
        send8(1523, 1'b0, 1'b1, 1'b0, -1);
        q8.push_back({3'b000, 11'd64});
        send8(64, 1'b0, 1'b1, 1'b0, -1);
        q8.push_back({3'b010, 11'd63});
        send8(63, 1'b0, 1'b1, 1'b0, -1);
        q8.push_back({3'b010, 11'd1});
        send8(1, 1'b0, 1'b1, 1'b0, -1);

        repeat (3) @(posedge clk);
        #1;
        send8(80, 1'b1, 1'b1, 1'b0, -1);
        check("drop_bad_ovf_pulse", 32'(ovf8), 0);
        check("drop_bad_occupancy", 32'(occ8), 0);
        check("drop_bad_ovf_count", 32'(cnt8), 0);

        bus8.m_len_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4)
                q8.push_back({3'b000, 11'(64 + k)});
            send8(64 + k, 1'b0, 1'b1, 1'b0, -1);
            if (k == 3)
                check("full_no_overflow", 32'(ovf8), 0);
        end
        check("overflow_pulse", 32'(ovf8), 1);
        check("overflow_count", 32'(cnt8), 1);
        check("overflow_occupancy", 32'(occ8), 4);
        check("stall_hold_tdata", 32'(bus8.m_len_tdata), 64);
        check("stall_hold_tvalid", 32'(bus8.m_len_tvalid), 1);
        @(posedge clk); #1;
        check("overflow_one_cycle", 32'(ovf8), 0);
        check("stall_hold_tdata_later", 32'(bus8.m_len_tdata), 64);

        q8.push_back({3'b000, 11'd69});
        send8(69, 1'b0, 1'b1, 1'b1, -1);
        check("full_pushpop_occupancy", 32'(occ8), 4);
        check("full_pushpop_no_pulse", 32'(ovf8), 0);
        check("full_pushpop_count", 32'(cnt8), 1);
        repeat (8) @(posedge clk);
        #1;
        check("drained_occupancy", 32'(occ8), 0);

        send8(30, 1'b0, 1'b0, 1'b0, -1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midframe_reset_count", 32'(cnt8), 0);
        check("midframe_reset_occ", 32'(occ8), 0);
        rst = 1'b1;
        q8.push_back({3'b000, 11'd70});
        send8(70, 1'b0, 1'b1, 1'b0, -1);

        repeat (5) @(posedge clk);
        #1;
        check("u8_queue_drained", 32'(q8.size()), 0);
        check("u32_queue_drained", 32'(q32.size()), 0);
        check("u32_no_overflow", 32'(cnt32), 0);
        check("u32_occupancy", 32'(occ32), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
